pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_pkg.sv | 16 +
 rtl/ras_stack.sv | 54 +++++
 rtl/pc_sequencer.sv | 101 ++++++++++
 tb/tb_pc_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the PC sequencer: op encoding and default parameters.
package pc_pkg;

  typedef enum logic [1:0] {
    OP_SEQ  = 2'b00,
    OP_JUMP = 2'b01,
    OP_CALL = 2'b10,
    OP_RET  = 2'b11
  } op_e;

  localparam int DEF_ADDR_W     = 16;
  localparam int DEF_INC        = 1;
  localparam int DEF_RAS_DEPTH  = 4;   // must be a power of two, >= 2
  localparam int DEF_RESET_ADDR = 0;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack. When full, a push overwrites the oldest
// entry and the count saturates at DEPTH. Entry storage is not reset; the
// count guards every read, so stale data is never consumed.
module ras_stack
  import pc_pkg::*;
#(
  parameter int DEPTH = DEF_RAS_DEPTH,
  parameter int W     = DEF_ADDR_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PW-1:0]           ptr;    // next slot to write; top lives at ptr-1
  logic [CW-1:0]           count;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign top   = mem[ptr - 1'b1];

  // Pointer/count: flush empties, push wraps circularly, pop only when non-empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (flush) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + 1'b1;
      if (!full) count <= count + 1'b1;
    end else if (pop && !empty) begin
      ptr   <= ptr - 1'b1;
      count <= count - 1'b1;
    end
  end

  // Entry storage: write at the pointer; wrapping onto the oldest slot when full.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[ptr] <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer: SEQ/JUMP/CALL/RET with a return-address stack,
// redirect, stall, sticky self-loop halt and a registered RET-underflow pulse.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                ADDR_W     = DEF_ADDR_W,
  parameter int                INC        = DEF_INC,
  parameter int                RAS_DEPTH  = DEF_RAS_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(DEF_RESET_ADDR)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] target,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [ADDR_W-1:0] pc,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_underflow,
  output logic              halted
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INC);

  op_e               op_q;
  logic              active;     // op is honoured this cycle
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] ras_top;
  logic [ADDR_W-1:0] pc_nxt;
  logic              halt_set;
  logic              uf_nxt;
  logic              do_push;
  logic              do_pop;

  assign op_q    = op_e'(op);
  assign active  = !redirect && !halted && !stall;
  assign pc_inc  = pc + STEP;    // wraps modulo 2^ADDR_W
  assign do_push = active && (op_q == OP_CALL);
  assign do_pop  = active && (op_q == OP_RET) && !ras_empty;

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (ADDR_W)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (do_push),
    .pop       (do_pop),
    .push_data (pc_inc),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  // Next-PC select for an honoured op, with self-loop and underflow detection.
  always_comb begin
    pc_nxt   = pc;
    halt_set = 1'b0;
    uf_nxt   = 1'b0;
    if (active) begin
      case (op_q)
        OP_SEQ: pc_nxt = pc_inc;
        OP_JUMP, OP_CALL: begin
          pc_nxt   = target;
          halt_set = (target == pc);
        end
        OP_RET: begin
          if (!ras_empty) begin
            pc_nxt   = ras_top;
            halt_set = (ras_top == pc);
          end else begin
            pc_nxt = pc_inc;
            uf_nxt = 1'b1;
          end
        end
        default: pc_nxt = pc;
      endcase
    end
  end

  // Architectural state: redirect wins over halt/stall; halt is sticky until redirect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc            <= RESET_ADDR;
      halted        <= 1'b0;
      ras_underflow <= 1'b0;
    end else if (redirect) begin
      pc            <= redirect_addr;
      halted        <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      pc            <= pc_nxt;
      halted        <= halted | halt_set;
      ras_underflow <= uf_nxt;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: queue-based reference model checked every
// cycle, plus hand-computed literal expectations along the directed sequence.
module tb_pc_sequencer;
  import pc_pkg::*;

  localparam int AW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          stall = 1'b0;
  logic          redirect = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [AW-1:0] target = '0;
  logic [AW-1:0] redirect_addr = '0;
  logic [AW-1:0] pc;
  logic          ras_empty, ras_full, ras_underflow, halted;

  int tests = 0;
  int fails = 0;

  pc_sequencer #(
    .ADDR_W     (AW),
    .INC        (1),
    .RAS_DEPTH  (DEPTH),
    .RESET_ADDR (16'h0000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .op            (op),
    .target        (target),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .pc            (pc),
    .ras_empty     (ras_empty),
    .ras_full      (ras_full),
    .ras_underflow (ras_underflow),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  // Reference model: return addresses kept in a queue, newest at the back.
  logic [AW-1:0] m_pc = '0;
  logic [AW-1:0] m_stk[$];
  logic          m_halt = 1'b0;
  logic          m_uf = 1'b0;

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_pc = '0; m_stk.delete(); m_halt = 1'b0; m_uf = 1'b0;
    end else begin
      m_uf = 1'b0;
      if (redirect) begin
        m_pc = redirect_addr; m_stk.delete(); m_halt = 1'b0;
      end else if (!m_halt && !stall) begin
        if (op == OP_SEQ) m_pc = m_pc + 16'd1;
        else if (op == OP_JUMP) begin
          if (target == m_pc) m_halt = 1'b1;
          m_pc = target;
        end else if (op == OP_CALL) begin
          m_stk.push_back(m_pc + 16'd1);
          if (m_stk.size() > DEPTH) void'(m_stk.pop_front());
          if (target == m_pc) m_halt = 1'b1;
          m_pc = target;
        end else begin
          if (m_stk.size() == 0) begin
            m_pc = m_pc + 16'd1; m_uf = 1'b1;
          end else begin
            if (m_stk[$] == m_pc) m_halt = 1'b1;
            m_pc = m_stk.pop_back();
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    tests++;
    if (pc !== m_pc || ras_empty !== (m_stk.size() == 0) ||
        ras_full !== (m_stk.size() == DEPTH) || ras_underflow !== m_uf ||
        halted !== m_halt) begin
      fails++;
      $display("FAIL model t=%0t: got pc=%h empty=%b full=%b uf=%b halt=%b, want pc=%h empty=%b full=%b uf=%b halt=%b",
               $time, pc, ras_empty, ras_full, ras_underflow, halted,
               m_pc, (m_stk.size() == 0), (m_stk.size() == DEPTH), m_uf, m_halt);
    end
  end

  task automatic chk16(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  // Present an op for one edge; returns at the next negedge with results visible.
  task automatic step(input logic [1:0] o, input logic [AW-1:0] t);
    op = o; target = t;
    @(negedge clk);
  endtask

  task automatic redir(input logic [AW-1:0] a);
    redirect = 1'b1; redirect_addr = a;
    @(negedge clk);
    redirect = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk16("reset pc", pc, 16'h0000);
    chk1("reset empty", ras_empty, 1'b1);
    chk1("reset halted", halted, 1'b0);
    chk1("reset uf", ras_underflow, 1'b0);
    reset = 1'b1;

    // sequential advance and wrap
    step(OP_SEQ, '0); chk16("seq1", pc, 16'h0001);
    step(OP_SEQ, '0); chk16("seq2", pc, 16'h0002);
    step(OP_SEQ, '0); chk16("seq3", pc, 16'h0003);
    redir(16'hFFFF);  chk16("redir ffff", pc, 16'hFFFF);
    step(OP_SEQ, '0); chk16("wrap", pc, 16'h0000);

    // single call / return
    redir(16'h0010);
    step(OP_CALL, 16'h0100); chk16("call", pc, 16'h0100);
    step(OP_SEQ, '0);        chk16("call seq1", pc, 16'h0101);
    step(OP_SEQ, '0);        chk16("call seq2", pc, 16'h0102);
    step(OP_RET, '0);        chk16("ret", pc, 16'h0011);
    chk1("empty after ret", ras_empty, 1'b1);

    // five nested calls into a depth-4 stack
    redir(16'h1000);
    step(OP_CALL, 16'h2000);
    step(OP_CALL, 16'h3000);
    step(OP_CALL, 16'h4000);
    chk1("not full at 3", ras_full, 1'b0);
    step(OP_CALL, 16'h5000); chk1("full at 4", ras_full, 1'b1);
    step(OP_CALL, 16'h6000); chk1("full at 5", ras_full, 1'b1);
    step(OP_RET, '0); chk16("ret A5", pc, 16'h5001);
    step(OP_RET, '0); chk16("ret A4", pc, 16'h4001);
    step(OP_RET, '0); chk16("ret A3", pc, 16'h3001);
    step(OP_RET, '0); chk16("ret A2", pc, 16'h2001);
    step(OP_RET, '0); chk16("empty ret pc", pc, 16'h2002);
    chk1("uf pulse", ras_underflow, 1'b1);
    step(OP_SEQ, '0); chk1("uf cleared", ras_underflow, 1'b0);
    chk16("after uf", pc, 16'h2003);

    // stall holds everything, self-target under stall does not halt
    step(OP_CALL, 16'h0300);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(OP_CALL, 16'h0200);
      chk16("stall pc", pc, 16'h0300);
      chk1("stall empty", ras_empty, 1'b0);
    end
    step(OP_JUMP, 16'h0300); chk1("stall no halt", halted, 1'b0);
    step(OP_RET, '0);        chk16("stall ret pc", pc, 16'h0300);
    stall = 1'b0;
    step(OP_SEQ, '0); chk16("unstall", pc, 16'h0301);

    // jump self-loop halts; redirect releases and flushes
    step(OP_CALL, 16'h0040);
    step(OP_JUMP, 16'h0040); chk1("halt set", halted, 1'b1);
    chk16("halt pc", pc, 16'h0040);
    step(OP_SEQ, '0);        chk16("halt seq", pc, 16'h0040);
    step(OP_CALL, 16'h0500); chk16("halt call", pc, 16'h0040);
    chk1("halt keeps stack", ras_empty, 1'b0);
    redir(16'h0080); chk16("redir pc", pc, 16'h0080);
    chk1("redir halt", halted, 1'b0);
    chk1("redir empty", ras_empty, 1'b1);

    // return self-loop halts
    redir(16'h0700);
    step(OP_CALL, 16'h06FF);
    step(OP_SEQ, '0);
    step(OP_SEQ, '0);
    step(OP_RET, '0); chk16("ret loop pc", pc, 16'h0701);
    chk1("ret loop halt", halted, 1'b1);
    redir(16'h0123); chk1("ret loop cleared", halted, 1'b0);

    // asynchronous reset mid-CALL discards the push
    op = OP_CALL; target = 16'h0900;
    #2 reset = 1'b0;
    #1;
    chk16("async pc", pc, 16'h0000);
    chk1("async empty", ras_empty, 1'b1);
    chk1("async halt", halted, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    step(OP_SEQ, '0); chk16("post reset seq", pc, 16'h0001);
    chk1("post reset empty", ras_empty, 1'b1);
    step(OP_RET, '0); chk16("post reset ret", pc, 16'h0002);
    chk1("post reset uf", ras_underflow, 1'b1);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
